// File: rtl/alt_vip_common_avalon_mm_csr_shadow.sv
// alt_vip_common_avalon_mm_csr_shadow
//
// Avalon-MM control/status slave for VIP cores. Register map (word addresses):
//   0      control : bit0 = go (enable), bits NO_INTERRUPTS:1 = interrupt enables
//   1      status  : bit0 = &stopped, bit1 = commit pending (read-only)
//   2      irq     : bits NO_INTERRUPTS:1 latched sources, write-1-to-clear
//   3      commit  : any write requests a commit at the next opportunity
//   4+i    user register i
//
// Optional feature, macro ALT_VIP_CSR_SHADOW_EN:
//   defined   - user registers are double-buffered. The master writes staging
//               copies and the core sees active copies that update together
//               when a commit is pending and either frame_boundary pulses or
//               all outputs are stopped. Only registers written since the last
//               commit pulse their trigger.
//   undefined - no staging storage; master writes go straight to the active
//               registers and pulse the trigger on the following cycle. The
//               commit register is ignored and frame_boundary is unused.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   av_*              Avalon-MM slave with byte enables and READ_LATENCY (1 or 2)
//                     cycle pipelined reads flagged by av_readdatavalid
//   av_irq            OR of the latched, enabled interrupt bits
//   enable            go bit; clear_enable clears it (a master write wins)
//   frame_boundary    start-of-frame pulse, commit opportunity
//   triggers          one-cycle pulse per active-register update
//   registers         active user registers, reg i at [i*W +: W]
//   registers_in/_write  internal write path (ALLOW_INTERNAL_WRITE = 1)
//   interrupts        interrupt source pulses
//   stopped           per-output stopped flags

module alt_vip_common_avalon_mm_csr_shadow #(
  parameter int unsigned AV_ADDRESS_WIDTH     = 5,
  parameter int unsigned AV_DATA_WIDTH        = 32,
  parameter int unsigned NO_OUTPUTS           = 1,
  parameter int unsigned NO_INTERRUPTS        = 2,
  parameter int unsigned NO_REGISTERS         = 8,
  parameter int unsigned ALLOW_INTERNAL_WRITE = 0,
  parameter int unsigned READ_LATENCY         = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [AV_ADDRESS_WIDTH-1:0]             av_address,
  input  logic                                    av_read,
  output logic [AV_DATA_WIDTH-1:0]                av_readdata,
  output logic                                    av_readdatavalid,
  input  logic                                    av_write,
  input  logic [AV_DATA_WIDTH-1:0]                av_writedata,
  input  logic [AV_DATA_WIDTH/8-1:0]              av_byteenable,
  output logic                                    av_irq,
  output logic                                    enable,
  input  logic                                    clear_enable,
  input  logic                                    frame_boundary,
  output logic [NO_REGISTERS-1:0]                 triggers,
  output logic [AV_DATA_WIDTH*NO_REGISTERS-1:0]   registers,
  input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0]   registers_in,
  input  logic [NO_REGISTERS-1:0]                 registers_write,
  input  logic [NO_INTERRUPTS-1:0]                interrupts,
  input  logic [NO_OUTPUTS-1:0]                   stopped
);

  localparam int unsigned DW = AV_DATA_WIDTH;
  localparam int unsigned AW = AV_ADDRESS_WIDTH;
  localparam int unsigned NR = NO_REGISTERS;
  localparam int unsigned NI = NO_INTERRUPTS;

  // ---------------------------------------------------------------------------
  // Byte-enable expansion and address decode
  // ---------------------------------------------------------------------------
  logic [DW-1:0] be_mask;
  logic [DW-1:0] reg_in [NR];
  logic [NR-1:0] wr_user;
  logic          wr_ctrl;
  logic          wr_irq;
  logic          all_stopped;

  for (genvar b = 0; b < DW / 8; b++) begin : g_be
    assign be_mask[b*8 +: 8] = {8{av_byteenable[b]}};
  end

  for (genvar i = 0; i < NR; i++) begin : g_user_dec
    assign wr_user[i] = av_write && (av_address == AW'(i + 4));
    assign reg_in[i]  = registers_in[i*DW +: DW];
  end

  assign wr_ctrl     = av_write && (av_address == AW'(0));
  assign wr_irq      = av_write && (av_address == AW'(2));
  assign all_stopped = &stopped;

  // ---------------------------------------------------------------------------
  // Control and interrupt registers
  // ---------------------------------------------------------------------------
  logic          enable_q, enable_d;
  logic [NI-1:0] irq_en_q, irq_en_d;
  logic [NI-1:0] irq_q, irq_d;
  logic [DW-1:0] ctrl_rd;
  logic [DW-1:0] ctrl_new;

  assign ctrl_rd  = DW'({irq_en_q, enable_q});
  assign ctrl_new = (ctrl_rd & ~be_mask) | (av_writedata & be_mask);

  always_comb begin
    enable_d = enable_q;
    if (clear_enable) begin
      enable_d = 1'b0;
    end
    // A master write to the go bit overrides the internal clear.
    if (wr_ctrl && av_byteenable[0]) begin
      enable_d = av_writedata[0];
    end

    irq_en_d = wr_ctrl ? ctrl_new[NI:1] : irq_en_q;

    irq_d = irq_q | (interrupts & irq_en_q);
    if (wr_irq) begin
      // Clear is applied after set so it wins a same-cycle collision.
      irq_d = irq_d & ~(av_writedata[NI:1] & be_mask[NI:1]);
    end
    // Disabled sources never hold a latched bit.
    irq_d = irq_d & irq_en_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= 1'b0;
      irq_en_q <= '0;
      irq_q    <= '0;
    end else begin
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign enable = enable_q;
  assign av_irq = |irq_q;

  // ---------------------------------------------------------------------------
  // User registers
  // ---------------------------------------------------------------------------
  logic [DW-1:0] active_q [NR];
  logic [DW-1:0] active_d [NR];
  logic [DW-1:0] user_rd  [NR];
  logic [NR-1:0] triggers_q, triggers_d;
  logic          commit_pending;

`ifdef ALT_VIP_CSR_SHADOW_EN
  logic [DW-1:0] staging_q [NR];
  logic [DW-1:0] staging_d [NR];
  logic [NR-1:0] dirty_q, dirty_d;
  logic          pending_q, pending_d;
  logic          wr_commit;
  logic          commit_fire;

  assign wr_commit      = av_write && (av_address == AW'(3));
  assign commit_pending = pending_q;
  assign commit_fire    = pending_q && (frame_boundary || all_stopped);

  always_comb begin
    // A commit write landing on a firing commit re-arms for the next opportunity.
    pending_d  = (pending_q && !commit_fire) || wr_commit;
    triggers_d = commit_fire ? dirty_q : '0;
    for (int i = 0; i < int'(NR); i++) begin
      staging_d[i] = staging_q[i];
      active_d[i]  = active_q[i];
      dirty_d[i]   = dirty_q[i] && !commit_fire;
      if ((ALLOW_INTERNAL_WRITE != 0) && registers_write[i]) begin
        staging_d[i] = reg_in[i];
        active_d[i]  = reg_in[i];
      end
      if (wr_user[i]) begin
        staging_d[i] = (staging_q[i] & ~be_mask) | (av_writedata & be_mask);
        dirty_d[i]   = 1'b1;
      end
      if (commit_fire) begin
        active_d[i] = staging_q[i];
      end
      user_rd[i] = staging_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      dirty_q   <= '0;
      for (int i = 0; i < int'(NR); i++) begin
        staging_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
      staging_q <= staging_d;
    end
  end
`else
  logic unused_frame_boundary;

  assign unused_frame_boundary = frame_boundary;
  assign commit_pending        = 1'b0;

  always_comb begin
    triggers_d = wr_user;
    for (int i = 0; i < int'(NR); i++) begin
      active_d[i] = active_q[i];
      if ((ALLOW_INTERNAL_WRITE != 0) && registers_write[i]) begin
        active_d[i] = reg_in[i];
      end
      // Master write applied last so it wins over the internal path.
      if (wr_user[i]) begin
        active_d[i] = (active_q[i] & ~be_mask) | (av_writedata & be_mask);
      end
      user_rd[i] = active_q[i];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      triggers_q <= '0;
      for (int i = 0; i < int'(NR); i++) begin
        active_q[i] <= '0;
      end
    end else begin
      triggers_q <= triggers_d;
      active_q   <= active_d;
    end
  end

  assign triggers = triggers_q;

  for (genvar i = 0; i < NR; i++) begin : g_reg_out
    assign registers[i*DW +: DW] = active_q[i];
  end

  // ---------------------------------------------------------------------------
  // Read path: mux on current register state (so a same-cycle write is not
  // visible), then a READ_LATENCY deep pipeline. Data stages only load when
  // their valid advances, so readdata holds between reads.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]           rd_mux;
  logic [READ_LATENCY-1:0] rd_valid_q;
  logic [DW-1:0]           rd_data_q [READ_LATENCY];

  always_comb begin
    rd_mux = '0;
    unique case (av_address)
      AW'(0):  rd_mux = ctrl_rd;
      AW'(1):  rd_mux = DW'({commit_pending, all_stopped});
      AW'(2):  rd_mux = DW'({irq_q, 1'b0});
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < int'(NR); i++) begin
      if (av_address == AW'(i + 4)) begin
        rd_mux = user_rd[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= '0;
      for (int s = 0; s < int'(READ_LATENCY); s++) begin
        rd_data_q[s] <= '0;
      end
    end else begin
      rd_valid_q[0] <= av_read;
      if (av_read) begin
        rd_data_q[0] <= rd_mux;
      end
      for (int s = 1; s < int'(READ_LATENCY); s++) begin
        rd_valid_q[s] <= rd_valid_q[s-1];
        if (rd_valid_q[s-1]) begin
          rd_data_q[s] <= rd_data_q[s-1];
        end
      end
    end
  end

  assign av_readdata      = rd_data_q[READ_LATENCY-1];
  assign av_readdatavalid = rd_valid_q[READ_LATENCY-1];

endmodule

// File: tb/tb_alt_vip_common_avalon_mm_csr_shadow.sv
`timescale 1ns/1ps
module tb_alt_vip_common_avalon_mm_csr_shadow;

  localparam int AW = 5;
  localparam int W  = 32;
  localparam int NO = 2;
  localparam int NI = 2;
  localparam int NR = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   av_address;
  logic            av_read, av_write;
  logic [W-1:0]    av_writedata;
  logic [W/8-1:0]  av_byteenable;
  logic            clear_enable, frame_boundary;
  logic [W*NR-1:0] registers_in;
  logic [NR-1:0]   registers_write;
  logic [NI-1:0]   interrupts;
  logic [NO-1:0]   stopped;

  logic [W-1:0]    d1_rdata, d2_rdata;
  logic            d1_valid, d2_valid;
  logic            d1_irq, d2_irq, d1_en, d2_en;
  logic [NR-1:0]   d1_trig, d2_trig;
  logic [W*NR-1:0] d1_regs, d2_regs;

  always #5 clk = ~clk;

  // Latency-1 and latency-2 instances share every input.
  alt_vip_common_avalon_mm_csr_shadow #(
    .AV_ADDRESS_WIDTH(AW), .AV_DATA_WIDTH(W), .NO_OUTPUTS(NO), .NO_INTERRUPTS(NI),
    .NO_REGISTERS(NR), .ALLOW_INTERNAL_WRITE(1), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .av_address(av_address), .av_read(av_read),
    .av_readdata(d1_rdata), .av_readdatavalid(d1_valid), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable), .av_irq(d1_irq),
    .enable(d1_en), .clear_enable(clear_enable), .frame_boundary(frame_boundary),
    .triggers(d1_trig), .registers(d1_regs), .registers_in(registers_in),
    .registers_write(registers_write), .interrupts(interrupts), .stopped(stopped)
  );

  alt_vip_common_avalon_mm_csr_shadow #(
    .AV_ADDRESS_WIDTH(AW), .AV_DATA_WIDTH(W), .NO_OUTPUTS(NO), .NO_INTERRUPTS(NI),
    .NO_REGISTERS(NR), .ALLOW_INTERNAL_WRITE(1), .READ_LATENCY(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .av_address(av_address), .av_read(av_read),
    .av_readdata(d2_rdata), .av_readdatavalid(d2_valid), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable), .av_irq(d2_irq),
    .enable(d2_en), .clear_enable(clear_enable), .frame_boundary(frame_boundary),
    .triggers(d2_trig), .registers(d2_regs), .registers_in(registers_in),
    .registers_write(registers_write), .interrupts(interrupts), .stopped(stopped)
  );

  typedef struct {
    logic [W-1:0] data;
    int unsigned  due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: pop on every valid, flag data/cycle mismatch or a missed slot.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (d1_valid) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL rd_lat1 unexpected valid, data %h", d1_rdata);
        end else begin
          e = q1.pop_front();
          if (d1_rdata !== e.data || cyc != e.due) begin
            n_err++;
            $display("FAIL rd_lat1 got %h at cycle %0d, want %h at cycle %0d",
                     d1_rdata, cyc, e.data, e.due);
          end
        end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
        n_vec++;
        n_err++;
        e = q1.pop_front();
        $display("FAIL rd_lat1 no valid at cycle %0d, want %h", cyc, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (d2_valid) begin
        n_vec++;
        if (q2.size() == 0) begin
          n_err++;
          $display("FAIL rd_lat2 unexpected valid, data %h", d2_rdata);
        end else begin
          e = q2.pop_front();
          if (d2_rdata !== e.data || cyc != e.due) begin
            n_err++;
            $display("FAIL rd_lat2 got %h at cycle %0d, want %h at cycle %0d",
                     d2_rdata, cyc, e.data, e.due);
          end
        end
      end else if (q2.size() != 0 && q2[0].due <= cyc) begin
        n_vec++;
        n_err++;
        e = q2.pop_front();
        $display("FAIL rd_lat2 no valid at cycle %0d, want %h", cyc, e.data);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle; a read pushes its expected data for both latencies.
  task automatic op(input logic rd, input logic wr, input logic [AW-1:0] a,
                    input logic [W-1:0] d, input logic [3:0] be, input logic [W-1:0] exp_rd);
    exp_t e;
    av_read       = rd;
    av_write      = wr;
    av_address    = a;
    av_writedata  = d;
    av_byteenable = be;
    if (rd) begin
      e.data = exp_rd;
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc + 2;
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
    av_read       = 1'b0;
    av_write      = 1'b0;
    av_byteenable = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] exp_rd);
    op(1'b1, 1'b0, a, '0, 4'h0, exp_rd);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] be);
    op(1'b0, 1'b1, a, d, be, '0);
  endtask

  function automatic logic [W-1:0] reg2(input int i);
    return d2_regs[i*W +: W];
  endfunction

  initial begin
    exp_t e;
    rst = 1'b1;
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
    clear_enable = 0; frame_boundary = 0; registers_in = '0; registers_write = '0;
    interrupts = '0; stopped = '0;
    idle(3);
    check("rst_enable", W'(d2_en), 0);
    check("rst_irq", W'(d2_irq), 0);
    check("rst_triggers", W'(d2_trig), 0);
    check("rst_registers", W'(|d2_regs), 0);
    check("rst_valid", W'({d1_valid, d2_valid}), 0);
    check("rst_rdata", d2_rdata, 0);
    rst = 1'b0;
    idle(1);

    // Full map reads back zero, back to back, including unmapped addresses.
    for (int a = 0; a <= 4 + NR; a++) rd(AW'(a), 0);
    rd(5'd31, 0);

    // Control, with a same-cycle read returning the pre-write value.
    wr(0, 32'h5, 4'hF);
    check("ctrl_enable_set", W'(d2_en), 1);
    op(1'b1, 1'b1, 0, 32'h3, 4'hF, 32'h5);
    rd(0, 32'h3);
    wr(0, 32'h5, 4'hF);
    wr(0, 32'hFF, 4'hE);
    rd(0, 32'h5);
    idle(3);
    check("rdata_hold_l1", d1_rdata, 32'h5);
    check("rdata_hold_l2", d2_rdata, 32'h5);

    // Interrupts.
    interrupts = 2'b10; idle(1); interrupts = '0;
    check("irq_set", W'(d2_irq), 1);
    rd(2, 32'h4);
    interrupts = 2'b01; idle(1); interrupts = '0;
    rd(2, 32'h4);
    wr(2, 32'h4, 4'h0);
    check("irq_clear_be0", W'(d2_irq), 1);
    wr(2, 32'h4, 4'hF);
    check("irq_clear", W'(d2_irq), 0);
    interrupts = 2'b10;
    wr(2, 32'h4, 4'hF);
    interrupts = '0;
    check("irq_clear_beats_set", W'(d2_irq), 0);
    rd(2, 32'h0);
    interrupts = 2'b10; idle(1); interrupts = '0;
    wr(0, 32'h1, 4'hF);
    check("irq_forced_by_disable", W'(d2_irq), 0);
    rd(2, 32'h0);

    // clear_enable priority.
    clear_enable = 1;
    wr(0, 32'h1, 4'hF);
    clear_enable = 0;
    check("clear_vs_write", W'(d2_en), 1);
    clear_enable = 1; idle(1); clear_enable = 0;
    check("clear_enable", W'(d2_en), 0);
    rd(0, 32'h0);

    // Status stopped AND.
    stopped = 2'b01; rd(1, 32'h0);
    stopped = 2'b11; rd(1, 32'h1);
    stopped = 2'b00;

`ifdef ALT_VIP_CSR_SHADOW_EN
    wr(5, 32'h12345678, 4'b0011);
    rd(5, 32'h00005678);
    check("staged_not_active", reg2(1), 0);
    check("staged_no_trigger", W'(d2_trig), 0);
    wr(3, 32'h0, 4'hF);
    rd(1, 32'h2);
    frame_boundary = 1; idle(1); frame_boundary = 0;
    check("commit_reg1", reg2(1), 32'h5678);
    check("commit_trig", W'(d2_trig), 32'h2);
    idle(1);
    check("commit_trig_pulse", W'(d2_trig), 0);
    rd(1, 32'h0);

    // Commit write colliding with a firing commit stays pending.
    wr(3, 32'h0, 4'hF);
    frame_boundary = 1;
    wr(3, 32'h0, 4'hF);
    frame_boundary = 0;
    rd(1, 32'h2);
    frame_boundary = 1; idle(1); frame_boundary = 0;
    rd(1, 32'h0);

    // Commit beats internal write on active; internal write still lands in staging.
    wr(4, 32'h55, 4'hF);
    wr(3, 32'h0, 4'hF);
    frame_boundary = 1; registers_write = 8'h01; registers_in[0 +: W] = 32'hAA;
    idle(1);
    frame_boundary = 0; registers_write = '0;
    check("commit_beats_internal", reg2(0), 32'h55);
    check("commit_trig0", W'(d2_trig), 32'h1);
    rd(4, 32'hAA);

    // Commit while all outputs stopped.
    wr(6, 32'h99, 4'hF);
    wr(3, 32'h0, 4'hF);
    stopped = 2'b11; idle(1); stopped = 2'b00;
    check("stopped_commit", reg2(2), 32'h99);
    check("stopped_trig", W'(d2_trig), 32'h4);
    rd(1, 32'h0);

    registers_write = 8'h08; registers_in = '0; registers_in[3*W +: W] = 32'h33;
    idle(1);
    registers_write = '0;
    check("internal_active", reg2(3), 32'h33);
    check("internal_no_trig", W'(d2_trig), 0);
    rd(7, 32'h33);
`else
    wr(5, 32'h12345678, 4'b0011);
    check("direct_reg1", reg2(1), 32'h5678);
    check("direct_trig1", W'(d2_trig), 32'h2);
    idle(1);
    check("direct_trig_pulse", W'(d2_trig), 0);
    rd(5, 32'h00005678);
    wr(4, 32'hDEADBEEF, 4'hF);
    check("direct_reg0", reg2(0), 32'hDEADBEEF);
    check("direct_trig0", W'(d2_trig), 32'h1);
    wr(3, 32'h0, 4'hF);
    rd(1, 32'h0);

    registers_write = 8'h04; registers_in = '0; registers_in[2*W +: W] = 32'hAA;
    idle(1);
    registers_write = '0;
    check("internal_active", reg2(2), 32'hAA);
    check("internal_no_trig", W'(d2_trig), 0);
    registers_write = 8'h04; registers_in[2*W +: W] = 32'hBB;
    wr(6, 32'h77, 4'hF);
    registers_write = '0;
    check("master_beats_internal", reg2(2), 32'h77);
    check("master_trig2", W'(d2_trig), 32'h4);
    rd(6, 32'h77);
`endif

    idle(4);

    // Reset mid-read: latency-2 pending valid is discarded.
    e.data = 32'h5678;
    e.due  = cyc + 1;
    q1.push_back(e);
    av_read = 1; av_address = 5;
    @(posedge clk); #1;
    av_read = 0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_drops_valid", W'(d2_valid), 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    check("post_rst_reg1", reg2(1), 0);
    rd(5, 32'h0);
    idle(4);
    check("q1_drained", W'(q1.size()), 0);
    check("q2_drained", W'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
